// File: rtl/masked_and_or_pipe.sv
`default_nettype none
// ============================================================================
// Module   : masked_and_or_pipe
// Purpose  : Two-share Boolean-masked AND-OR reduction y = OR_i (a[i] & b[i])
//            over NPAIRS lane pairs. Each layer is a registered DOM-indep AND
//            gadget, so glitches cannot combine shares across a layer. The
//            pipeline uses valid/ready handshakes. Shares are never recombined
//            inside the block.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1       rising-edge clock
//   rst_n      in   1       asynchronous active-low reset
//   in_valid   in   1       input beat valid
//   in_ready   out  1       beat accepted when in_valid & in_ready
//   a0, a1     in   N       shares of operand a (a = a0 ^ a1)
//   b0, b1     in   N       shares of operand b (b = b0 ^ b1)
//   rnd        in   RW      fresh randomness (absent with MASKED_PRNG_EN)
//   out_valid  out  1       result valid
//   out_ready  in   1       downstream accepts result
//   out0, out1 out  1       shares of y
//   out_n0     out  1       share 0 of ~y (= ~out0)
//   out_n1     out  1       share 1 of ~y (= out1)
// Configuration macro
//   MASKED_PRNG_EN : removes the rnd port and derives randomness from an
//                    internal 32-bit Fibonacci LFSR (taps 32,22,2,1).
// ============================================================================
module masked_and_or_pipe #(
    parameter int LOG_PAIRS = 2,
    parameter int NPAIRS    = 1 << LOG_PAIRS,
    parameter int RW        = 2 * NPAIRS - 1
`ifdef MASKED_PRNG_EN
    ,
    parameter logic [31:0] LFSR_SEED = 32'hACE12468
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NPAIRS-1:0] a0,
    input  logic [NPAIRS-1:0] a1,
    input  logic [NPAIRS-1:0] b0,
    input  logic [NPAIRS-1:0] b1,
`ifndef MASKED_PRNG_EN
    input  logic [RW-1:0]     rnd,
`endif
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out0,
    output logic              out1,
    output logic              out_n0,
    output logic              out_n1
);

    localparam int N = NPAIRS;
    localparam int L = LOG_PAIRS;

    // Node storage is a flat tree: lanes occupy [0, N), layer k occupies
    // [2N - 2*(N>>k), 2N - (N>>k)), the root sits at RW-1. This is the same
    // layout as the randomness vector, so a node's fresh bit shares its index.
    logic [RW-1:0] r_s0;
    logic [RW-1:0] r_s1;
    logic [RW-1:0] w_s0_nxt;
    logic [RW-1:0] w_s1_nxt;
    logic [L:0]    r_valid;
    logic [RW-1:0] w_rnd;
    logic          w_en;

    // ------------------------------------------------------------------
    // Randomness source
    // ------------------------------------------------------------------
`ifdef MASKED_PRNG_EN
    if (LOG_PAIRS > 4) begin : g_bad_cfg
        $error("masked_and_or_pipe: LOG_PAIRS > 4 not supported with internal PRNG");
    end

    logic [31:0] r_lfsr;
    logic        w_lfsr_fb;

    assign w_lfsr_fb = r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= LFSR_SEED;
        end else if (w_en) begin
            r_lfsr <= {r_lfsr[30:0], w_lfsr_fb};
        end
    end

    assign w_rnd = r_lfsr[RW-1:0];
`else
    assign w_rnd = rnd;
`endif

    // ------------------------------------------------------------------
    // Handshake: the whole pipeline advances together unless a valid
    // result is being held for a stalled consumer.
    // ------------------------------------------------------------------
    assign w_en      = out_ready | ~out_valid;
    assign in_ready  = w_en;
    assign out_valid = r_valid[L];

    // ------------------------------------------------------------------
    // Layer 0: per-lane DOM AND. The cross term is blinded by r before it
    // meets the domain-local term, and the result is registered at once.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < N; i++) begin : g_lane
        assign w_s0_nxt[i] = (a0[i] & b0[i]) ^ ((a0[i] & b1[i]) ^ w_rnd[i]);
        assign w_s1_nxt[i] = (a1[i] & b1[i]) ^ ((a1[i] & b0[i]) ^ w_rnd[i]);
    end

    // ------------------------------------------------------------------
    // Layers 1..L: OR of two masked bits as x ^ z ^ (x & z). The AND is a
    // DOM gadget; the linear part is computed per share from registered
    // operands and folded into the same stage register.
    // ------------------------------------------------------------------
    for (genvar k = 1; k <= L; k++) begin : g_layer
        localparam int OFF_IN  = 2 * N - 2 * (N >> (k - 1));
        localparam int OFF_OUT = 2 * N - 2 * (N >> k);
        for (genvar j = 0; j < (N >> k); j++) begin : g_node
            logic w_x0;
            logic w_x1;
            logic w_z0;
            logic w_z1;
            assign w_x0 = r_s0[OFF_IN + 2 * j];
            assign w_x1 = r_s1[OFF_IN + 2 * j];
            assign w_z0 = r_s0[OFF_IN + 2 * j + 1];
            assign w_z1 = r_s1[OFF_IN + 2 * j + 1];
            assign w_s0_nxt[OFF_OUT + j] = (w_x0 & w_z0)
                                         ^ ((w_x0 & w_z1) ^ w_rnd[OFF_OUT + j])
                                         ^ w_x0 ^ w_z0;
            assign w_s1_nxt[OFF_OUT + j] = (w_x1 & w_z1)
                                         ^ ((w_x1 & w_z0) ^ w_rnd[OFF_OUT + j])
                                         ^ w_x1 ^ w_z1;
        end
    end

    // ------------------------------------------------------------------
    // Pipeline registers: data and valid move in lock-step.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_s0    <= '0;
            r_s1    <= '0;
        end else if (w_en) begin
            r_valid <= {r_valid[L-1:0], in_valid};
            r_s0    <= w_s0_nxt;
            r_s1    <= w_s1_nxt;
        end
    end

    // Complement of a Boolean-masked bit: invert one share only.
    assign out0   = r_s0[RW-1];
    assign out1   = r_s1[RW-1];
    assign out_n0 = ~r_s0[RW-1];
    assign out_n1 = r_s1[RW-1];

endmodule
`default_nettype wire

// File: tb/tb_masked_and_or_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_masked_and_or_pipe
// Purpose  : Self-checking bench for masked_and_or_pipe (LOG_PAIRS=2, N=4).
//            A queue-based reference model holds y = ((a & b) != 0) for every
//            accepted beat and is compared, in order, with the recombined
//            output shares at each output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_masked_and_or_pipe;

    localparam int LOG_PAIRS = 2;
    localparam int N         = 4;
    localparam int RW        = 7;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  a0, a1, b0, b1;
    logic [RW-1:0] rnd;
    logic          out_valid;
    logic          out_ready;
    logic          out0, out1, out_n0, out_n1;

    int checks = 0;
    int errors = 0;
    int nres   = 0;
    int nacc   = 0;
    logic exp_q[$];
    logic pend_y;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic       y;
    } vec_t;

    vec_t tbl [8];

    masked_and_or_pipe #(.LOG_PAIRS(LOG_PAIRS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a0        (a0),
        .a1        (a1),
        .b0        (b0),
        .b1        (b1),
`ifndef MASKED_PRNG_EN
        .rnd       (rnd),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out0      (out0),
        .out1      (out1),
        .out_n0    (out_n0),
        .out_n1    (out_n1)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a beat with fresh random sharing; the model value is set here.
    task automatic drive(input logic [3:0] a, input logic [3:0] b,
                         input logic v, input logic ordy);
        a0        = 4'($urandom);
        a1        = a0 ^ a;
        b0        = 4'($urandom);
        b1        = b0 ^ b;
        rnd       = 7'($urandom);
        in_valid  = v;
        out_ready = ordy;
        pend_y    = ((a & b) != 4'd0);
    endtask

    // Called just after a falling edge with inputs set: observe both
    // handshakes, then advance to the next falling edge.
    task automatic cycle();
        logic y;
        #1;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_result: got out_valid=1 expected no pending beat");
            end else begin
                y = exp_q.pop_front();
                check("result", 32'({out0 ^ out1, out_n0 ^ out_n1}), 32'({y, ~y}));
                nres++;
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back(pend_y);
            nacc++;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            drive(4'd0, 4'd0, 1'b0, 1'b1);
            cycle();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int lat;
        int r0;
        int a0_cnt;
        logic [4:0] held;

        tbl[0] = '{a: 4'b0100, b: 4'b0100, y: 1'b1};
        tbl[1] = '{a: 4'b1111, b: 4'b0000, y: 1'b0};
        tbl[2] = '{a: 4'b1010, b: 4'b0101, y: 1'b0};
        tbl[3] = '{a: 4'b1000, b: 4'b1001, y: 1'b1};
        tbl[4] = '{a: 4'b0000, b: 4'b0000, y: 1'b0};
        tbl[5] = '{a: 4'b1111, b: 4'b1111, y: 1'b1};
        tbl[6] = '{a: 4'b0001, b: 4'b0001, y: 1'b1};
        tbl[7] = '{a: 4'b0110, b: 4'b1001, y: 1'b0};

        // ---------------- reset ----------------
        rst_n = 1'b0;
        drive(4'd0, 4'd0, 1'b0, 1'b1);
        @(negedge clk);
        @(negedge clk);
        check("reset_outputs", 32'({out_valid, out0, out1, out_n0, out_n1}), 32'(5'b00010));
        rst_n = 1'b1;
        #1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // ---------------- latency ----------------
        drive(4'b0100, 4'b0100, 1'b1, 1'b1);
        cycle();
        lat = 1;
        while (!out_valid && lat < 10) begin
            drive(4'd0, 4'd0, 1'b0, 1'b1);
            cycle();
            lat++;
        end
        check("latency", 32'(lat), 32'd3);
        drain();

        // ---------------- table vectors ----------------
        for (int i = 0; i < 8; i++) begin
            drive(tbl[i].a, tbl[i].b, 1'b1, 1'b1);
            pend_y = tbl[i].y;
            cycle();
        end
        drain();

        // ---------------- exhaustive back-to-back ----------------
        r0     = nres;
        a0_cnt = nacc;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive(4'(a), 4'(b), 1'b1, 1'b1);
                cycle();
            end
        end
        check("exh_accepted", 32'(nacc - a0_cnt), 32'd256);
        drain();
        check("exh_results", 32'(nres - r0), 32'd256);

        // ---------------- stall ----------------
        r0     = nres;
        a0_cnt = nacc;
        for (int i = 0; i < 3; i++) begin
            drive(4'($urandom), 4'($urandom), 1'b1, 1'b1);
            cycle();
        end
        check("stall_valid_before", 32'(out_valid), 32'd1);
        held = {out_valid, out0, out1, out_n0, out_n1};
        for (int i = 0; i < 5; i++) begin
            drive(4'($urandom), 4'($urandom), 1'b1, 1'b0);
            cycle();
            check("stall_hold", 32'({out_valid, out0, out1, out_n0, out_n1}), 32'(held));
            check("stall_in_ready", 32'(in_ready), 32'd0);
        end
        drive(4'($urandom), 4'($urandom), 1'b1, 1'b1);
        cycle();
        drain();
        check("stall_no_loss", 32'(nres - r0), 32'(nacc - a0_cnt));

        // ---------------- reset mid-flight ----------------
        for (int i = 0; i < 2; i++) begin
            drive(4'b1111, 4'b1111, 1'b1, 1'b1);
            cycle();
        end
        drive(4'd0, 4'd0, 1'b0, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_outputs", 32'({out_valid, out0, out1, out_n0, out_n1}), 32'(5'b00010));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        r0 = 0;
        for (int i = 0; i < 6; i++) begin
            drive(4'd0, 4'd0, 1'b0, 1'b1);
            #1;
            if (out_valid) r0++;
            cycle();
        end
        check("midreset_no_stale", 32'(r0), 32'd0);
        r0 = nres;
        drive(4'b1000, 4'b1001, 1'b1, 1'b1);
        cycle();
        drain();
        check("midreset_new_beat", 32'(nres - r0), 32'd1);

        // ---------------- randomized traffic ----------------
        r0     = nres;
        a0_cnt = nacc;
        for (int i = 0; i < 400; i++) begin
            drive(4'($urandom), 4'($urandom),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 7));
            cycle();
        end
        drain();
        check("random_count", 32'(nres - r0), 32'(nacc - a0_cnt));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
